snn_tile_sched: RTL and testbench
=================================

# snn_tile_sched

Sequencer for the `neuron_tile` datapath. It walks every layer, every tile and every input axon of the network. Zero input spikes are skipped, so only active axons cost a weight fetch. The block drives the tile's `enable`, `memReady` and `finished` strobes, issues weight and vmem memory requests, and commands vmem writeback once each tile completes. It sits between `snn_top`'s memories and spike buffers and its `neuron_tile` instance.

## Interface

Parameters:
- `size_counters`, default 5: width of the input-axon counter.
- `num_inputs`, default 32: axons per layer; must be ≤ 2**size_counters and ≥ 1.
- `num_tiles`, default 16: tiles per layer.
- `num_layers`, default 3: layers per inference.
- `TW` = $clog2(num_tiles), `LW` = $clog2(num_layers): derived widths, minimum 1.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: begin one inference; sampled only in IDLE.
- `busy`  out  1: high from the cycle after an accepted start until DONE exits.
- `done`  out  1: one-cycle pulse when the last layer writeback completes.
- `spike_addr`  out  size_counters: input spike buffer read address (current axon).
- `spike_bit`  in  1: spike buffer data, combinational for `spike_addr`.
- `mem_req`  out  1: weight/vmem read request.
- `mem_vmem`  out  1: 1 = vmem read, 0 = weight read; valid while `mem_req` is high.
- `mem_ack`  in  1: memory data valid on `weightData`/`vmemData` this cycle.
- `layer_idx`  out  LW: current layer.
- `tile_idx`  out  TW: current tile.
- `tile_enable`  out  1: `neuron_tile` enable.
- `tile_memReady`  out  1: one-cycle strobe; the tile captures data.
- `tile_finished`  out  1: one-cycle strobe; the tile thresholds and fires.
- `vmem_we`  out  1: one-cycle vmem writeback strobe for `vmemOut` at (layer_idx, tile_idx).

## Operation

- States: IDLE, LDV, SCAN, FETCH, CAPT, FIRE, WB, DONE.
- **IDLE**: `start` clears all counters and moves to LDV.
- **LDV**: `mem_req`=1 and `mem_vmem`=1 until `mem_ack`. On the ack cycle, go to CAPT with the vmem flag set.
- **SCAN**: `spike_addr` = input counter.
  - If `spike_bit`=1, go to FETCH.
  - Otherwise advance the counter. One axon is skipped per cycle.
  - After axon num_inputs-1 is processed or skipped, go to FIRE.
- **FETCH**: `mem_req`=1 and `mem_vmem`=0 until `mem_ack`, then go to CAPT.
- **CAPT**: `tile_memReady`=1 for exactly one cycle.
  - If this was the vmem load, go to SCAN with the counter at 0.
  - Otherwise advance the counter and go to SCAN, or to FIRE if this was the last axon.
- **FIRE**: `tile_finished`=1 for one cycle, then WB.
- **WB**: `vmem_we`=1 for one cycle.
  - Advance `tile_idx`, then go to LDV.
  - When `tile_idx` = num_tiles-1: wrap `tile_idx` to 0 and advance `layer_idx`, then go to LDV.
  - When both are at their maximum, go to DONE.
- **DONE**: `done`=1 for one cycle, then IDLE.
- `tile_enable` is high in every state except IDLE and DONE.
- Counters never exceed their terminal values. All wraps are explicit compares against parameter-1, never natural overflow.
- `mem_req` is held stable, with the address fields unchanged, until `mem_ack`. An ack outside LDV/FETCH is ignored.
- `start` while busy is ignored.
- A layer whose spike vector is all zeros still runs FIRE and WB for every tile, to apply leak and threshold.

## Timing

- Reset (async assert, sync release): state = IDLE; all outputs 0, including all counters and indices.
- Reset during any state aborts the run immediately. No partial `vmem_we` or strobe may follow.
- `start` in cycle t → LDV with `mem_req`=1 in cycle t+1; `busy`=1 from t+1.
- Memory latency is variable, ≥ 0 wait cycles: `mem_ack` may coincide with the first `mem_req` cycle.
- `mem_ack` at cycle t → `tile_memReady` at t+1.
- Last axon captured or skipped at t → `tile_finished` at t+1 → `vmem_we` at t+2.
- Per-tile cycles = 1 + L + 1 (vmem) + N_skip + Σ(L_i + 2) over active axons + 2, where L is ack wait cycles.

## Structure

- Shared package `snn_pkg`: state enum (`sched_state_t`), default sizes (size_counters, num_tiles, num_layers, num_inputs).
- One sub-module: `snn_idx_counter` (parameterised terminal-count counter with clear, inc and wrap flag), instantiated for axon, tile and layer.

## Test plan

- Reset mid-FETCH with `mem_req`=1 → next cycle all outputs 0 and state IDLE; a subsequent `start` runs cleanly from layer 0, tile 0.
- num_tiles=2, num_layers=1, num_inputs=4, spikes 1010, zero-latency ack → per tile: 1 vmem + 2 weight `tile_memReady` pulses; `spike_addr` sequence 0,1,2,3; `vmem_we` twice; `done` once; tile cycle count 10.
- All-zero spikes → no weight `mem_req`; each tile still gets exactly one `tile_finished` and one `vmem_we`.
- `mem_ack` delayed 3 cycles on every request → `mem_req` and `mem_vmem` held constant for 4 cycles; `tile_memReady` exactly 1 cycle after each ack.
- Default parameters, all spikes 1 → 3×16 `vmem_we` pulses in layer/tile order; `layer_idx` ends at 2, `tile_idx` at 15; `done` pulse then `busy`=0.
- `start` held high throughout a run → exactly one inference; a new run starts only after DONE returns to IDLE.

Source files
------------

// File: rtl/snn_pkg.sv
// snn_pkg
//   Shared definitions for the neuron-tile scheduler: the scheduler state
//   encoding, the default network sizes, and a helper that derives index
//   widths (never narrower than one bit).
package snn_pkg;

  localparam int SIZE_COUNTERS = 5;
  localparam int NUM_INPUTS    = 32;
  localparam int NUM_TILES     = 16;
  localparam int NUM_LAYERS    = 3;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LDV   = 3'd1,
    S_SCAN  = 3'd2,
    S_FETCH = 3'd3,
    S_CAPT  = 3'd4,
    S_FIRE  = 3'd5,
    S_WB    = 3'd6,
    S_DONE  = 3'd7
  } sched_state_t;

  // Width needed to index n items; a single item still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/snn_idx_counter.sv
// snn_idx_counter
//   Terminal-count index counter. Counts 0 .. term-1 and wraps back to 0 by
//   an explicit compare, so it never relies on natural overflow.
// Ports:
//   clk    in  1  clock, rising edge
//   reset  in  1  asynchronous active-high reset, count -> 0
//   clr    in  1  synchronous clear to 0 (wins over inc)
//   inc    in  1  advance by one, wrapping from term-1 to 0
//   count  out W  current index
//   last   out 1  count is at term-1 (wrap flag)
module snn_idx_counter
  import snn_pkg::*;
#(
  parameter int W    = 5,
  parameter int TERM = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count,
  output logic         last
);

  localparam logic [W-1:0] LAST_VAL = W'(TERM - 1);

  assign last = (count == LAST_VAL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/snn_tile_sched.sv
// snn_tile_sched
//   Sequencer for the neuron_tile datapath. For every layer and tile it loads
//   the tile's membrane potentials, walks the input axons skipping zero
//   spikes, fetches one weight row per active axon, fires the tile and
//   commands the vmem writeback.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   start             begin an inference (only looked at in IDLE)
//   busy, done        run in progress / one-cycle completion pulse
//   spike_addr        spike buffer read address (current axon)
//   spike_bit         spike buffer data for spike_addr (combinational)
//   mem_req, mem_vmem memory request; mem_vmem=1 selects vmem, 0 weights
//   mem_ack           memory data valid this cycle
//   layer_idx, tile_idx  current layer / tile
//   tile_enable, tile_memReady, tile_finished  neuron_tile controls
//   vmem_we           one-cycle vmem writeback strobe
module snn_tile_sched
  import snn_pkg::*;
#(
  parameter int  size_counters = SIZE_COUNTERS,
  parameter int  num_inputs    = NUM_INPUTS,
  parameter int  num_tiles     = NUM_TILES,
  parameter int  num_layers    = NUM_LAYERS,
  localparam int TW            = idx_width(num_tiles),
  localparam int LW            = idx_width(num_layers)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [size_counters-1:0] spike_addr,
  input  logic                     spike_bit,
  output logic                     mem_req,
  output logic                     mem_vmem,
  input  logic                     mem_ack,
  output logic [LW-1:0]            layer_idx,
  output logic [TW-1:0]            tile_idx,
  output logic                     tile_enable,
  output logic                     tile_memReady,
  output logic                     tile_finished,
  output logic                     vmem_we
);

  sched_state_t state, state_next;
  logic         vmem_flag, vmem_flag_next;

  logic axon_clr, axon_inc, axon_last;
  logic tile_clr, tile_inc, tile_last;
  logic layer_clr, layer_inc, layer_last;

  snn_idx_counter #(.W(size_counters), .TERM(num_inputs)) u_axon (
    .clk   (clk),
    .reset (reset),
    .clr   (axon_clr),
    .inc   (axon_inc),
    .count (spike_addr),
    .last  (axon_last)
  );

  snn_idx_counter #(.W(TW), .TERM(num_tiles)) u_tile (
    .clk   (clk),
    .reset (reset),
    .clr   (tile_clr),
    .inc   (tile_inc),
    .count (tile_idx),
    .last  (tile_last)
  );

  snn_idx_counter #(.W(LW), .TERM(num_layers)) u_layer (
    .clk   (clk),
    .reset (reset),
    .clr   (layer_clr),
    .inc   (layer_inc),
    .count (layer_idx),
    .last  (layer_last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      vmem_flag <= 1'b0;
    end else begin
      state     <= state_next;
      vmem_flag <= vmem_flag_next;
    end
  end

  always_comb begin
    state_next     = state;
    vmem_flag_next = vmem_flag;
    axon_clr       = 1'b0;
    axon_inc       = 1'b0;
    tile_clr       = 1'b0;
    tile_inc       = 1'b0;
    layer_clr      = 1'b0;
    layer_inc      = 1'b0;
    mem_req        = 1'b0;
    mem_vmem       = 1'b0;
    tile_memReady  = 1'b0;
    tile_finished  = 1'b0;
    vmem_we        = 1'b0;
    done           = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          axon_clr   = 1'b1;
          tile_clr   = 1'b1;
          layer_clr  = 1'b1;
          state_next = S_LDV;
        end
      end

      S_LDV: begin
        mem_req  = 1'b1;
        mem_vmem = 1'b1;
        if (mem_ack) begin
          vmem_flag_next = 1'b1;
          state_next     = S_CAPT;
        end
      end

      S_SCAN: begin
        if (spike_bit) begin
          // The weight request goes out in the scan cycle itself, so an
          // active axon costs only request + capture cycles. If the ack
          // is not immediate, FETCH holds the request with the axon
          // counter frozen.
          mem_req = 1'b1;
          if (mem_ack) begin
            state_next = S_CAPT;
          end else begin
            state_next = S_FETCH;
          end
        end else begin
          axon_inc = 1'b1;
          if (axon_last) begin
            state_next = S_FIRE;
          end
        end
      end

      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          state_next = S_CAPT;
        end
      end

      S_CAPT: begin
        tile_memReady = 1'b1;
        if (vmem_flag) begin
          vmem_flag_next = 1'b0;
          axon_clr       = 1'b1;
          state_next     = S_SCAN;
        end else begin
          axon_inc   = 1'b1;
          state_next = axon_last ? S_FIRE : S_SCAN;
        end
      end

      S_FIRE: begin
        tile_finished = 1'b1;
        state_next    = S_WB;
      end

      S_WB: begin
        vmem_we = 1'b1;
        if (tile_last && layer_last) begin
          // Leave the indices parked on the final layer/tile.
          state_next = S_DONE;
        end else begin
          tile_inc   = 1'b1;
          layer_inc  = tile_last;
          state_next = S_LDV;
        end
      end

      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign busy        = (state != S_IDLE);
  assign tile_enable = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: tb/tb_snn_tile_sched.sv
// tb_snn_tile_sched
//   Directed bench: a small scheduler (4 axons, 2 tiles, 2 layers) driven
//   from a table of spike patterns and memory latencies, plus hand-written
//   sequences for mid-run reset and held start, and one full default-size
//   inference with every spike active.
module tb_snn_tile_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- small instance ----------------
  logic       rst_s, start_s, busy_s, done_s, spike_s, req_s, vm_s, ack_s;
  logic [1:0] addr_s;
  logic [0:0] layer_s, tile_s;
  logic       en_s, mr_s, fin_s, we_s;
  logic [3:0] spikes_s;
  int         lat_s;
  int         wc_s;

  assign spike_s = spikes_s[addr_s];
  assign ack_s   = req_s && (wc_s == lat_s);

  always @(posedge clk or posedge rst_s) begin
    if (rst_s)               wc_s <= 0;
    else if (req_s && !ack_s) wc_s <= wc_s + 1;
    else                      wc_s <= 0;
  end

  snn_tile_sched #(
    .size_counters (2),
    .num_inputs    (4),
    .num_tiles     (2),
    .num_layers    (2)
  ) dut_s (
    .clk           (clk),
    .reset         (rst_s),
    .start         (start_s),
    .busy          (busy_s),
    .done          (done_s),
    .spike_addr    (addr_s),
    .spike_bit     (spike_s),
    .mem_req       (req_s),
    .mem_vmem      (vm_s),
    .mem_ack       (ack_s),
    .layer_idx     (layer_s),
    .tile_idx      (tile_s),
    .tile_enable   (en_s),
    .tile_memReady (mr_s),
    .tile_finished (fin_s),
    .vmem_we       (we_s)
  );

  // ---------------- default-size instance ----------------
  logic       rst_d, start_d, busy_d, done_d, spike_d, req_d, vm_d, ack_d;
  logic [4:0] addr_d;
  logic [1:0] layer_d;
  logic [3:0] tile_d;
  logic       en_d, mr_d, fin_d, we_d;

  assign spike_d = 1'b1;
  assign ack_d   = req_d;

  snn_tile_sched dut_d (
    .clk           (clk),
    .reset         (rst_d),
    .start         (start_d),
    .busy          (busy_d),
    .done          (done_d),
    .spike_addr    (addr_d),
    .spike_bit     (spike_d),
    .mem_req       (req_d),
    .mem_vmem      (vm_d),
    .mem_ack       (ack_d),
    .layer_idx     (layer_d),
    .tile_idx      (tile_d),
    .tile_enable   (en_d),
    .tile_memReady (mr_d),
    .tile_finished (fin_d),
    .vmem_we       (we_d)
  );

  // ---------------- bookkeeping ----------------
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Small-instance monitor, sampled on the falling edge.
  logic mon_clr;
  logic prev_req, prev_vm, prev_ack;
  int   run_len, n_busy, n_mr, n_fin, n_we, n_done, n_wreq, n_vreq;
  int   bad_mr, bad_hold, bad_run, bad_order, n_addr, bad_addr;

  always @(negedge clk) begin
    if (mon_clr) begin
      prev_req <= 1'b0; prev_vm <= 1'b0; prev_ack <= 1'b0;
      run_len <= 0; n_busy <= 0; n_mr <= 0; n_fin <= 0; n_we <= 0;
      n_done <= 0; n_wreq <= 0; n_vreq <= 0; bad_mr <= 0; bad_hold <= 0;
      bad_run <= 0; bad_order <= 0; n_addr <= 0; bad_addr <= 0;
    end else begin
      prev_req <= req_s;
      prev_vm  <= vm_s;
      prev_ack <= ack_s;
      // memReady must follow an ack by exactly one cycle.
      if (mr_s != prev_ack) bad_mr <= bad_mr + 1;
      if (req_s) begin
        if (prev_req && (vm_s != prev_vm)) bad_hold <= bad_hold + 1;
        run_len <= prev_req ? run_len + 1 : 1;
        if (vm_s) n_vreq <= n_vreq + 1;
        else      n_wreq <= n_wreq + 1;
      end else if (prev_req && (run_len != lat_s + 1)) begin
        bad_run <= bad_run + 1;
      end
      // Scan cycles: skips, or the first cycle of a weight request.
      if (en_s && !mr_s && !fin_s && !we_s && (!req_s || (!vm_s && !prev_req))) begin
        if (int'(addr_s) != (n_addr % 4)) bad_addr <= bad_addr + 1;
        n_addr <= n_addr + 1;
      end
      if (we_s) begin
        if (int'(layer_s) != n_we / 2 || int'(tile_s) != n_we % 2)
          bad_order <= bad_order + 1;
        n_we <= n_we + 1;
      end
      if (busy_s) n_busy <= n_busy + 1;
      if (mr_s)   n_mr   <= n_mr + 1;
      if (fin_s)  n_fin  <= n_fin + 1;
      if (done_s) n_done <= n_done + 1;
    end
  end

  // Default-instance monitor.
  int n_we_d, bad_order_d, n_done_d, n_fin_d;
  always @(negedge clk) begin
    if (rst_d) begin
      n_we_d <= 0; bad_order_d <= 0; n_done_d <= 0; n_fin_d <= 0;
    end else begin
      if (we_d) begin
        if (int'(layer_d) != n_we_d / 16 || int'(tile_d) != n_we_d % 16)
          bad_order_d <= bad_order_d + 1;
        n_we_d <= n_we_d + 1;
      end
      if (done_d) n_done_d <= n_done_d + 1;
      if (fin_d)  n_fin_d  <= n_fin_d + 1;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] spikes;   // bit i = spike on axon i
    int         lat;      // wait cycles on every memory request
    int         exp_busy; // 4 tiles x per-tile cycles + DONE
    int         exp_mr;   // 4 x (1 vmem + active axons)
    int         exp_wreq; // weight request cycles
    int         exp_vreq; // vmem request cycles
  } vec_t;

  vec_t vecs[5];

  // Run one inference on the small instance with start held high until DONE.
  task automatic run_small(output bit seen, output int lay, output int til);
    seen = 1'b0;
    lay  = -1;
    til  = -1;
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
    start_s = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (done_s) begin
        seen = 1'b1;
        lay  = int'(layer_s);
        til  = int'(tile_s);
        break;
      end
    end
    start_s = 1'b0;
    @(negedge clk);
    #1;
  endtask

  initial begin
    bit seen;
    int lay, til;

    // Per tile: 1 + L + 1 + N_skip + active*(L+2) + 2
    vecs[0] = '{4'b0101, 0, 41,  12, 8,  4};  // 10 cycles/tile
    vecs[1] = '{4'b0000, 0, 33,  4,  0,  4};  // 8
    vecs[2] = '{4'b1111, 3, 109, 20, 64, 16}; // 27
    vecs[3] = '{4'b1000, 1, 45,  8,  8,  8};  // 11
    vecs[4] = '{4'b0001, 2, 53,  8,  12, 12}; // 13

    rst_s = 1'b1; rst_d = 1'b1;
    start_s = 1'b0; start_d = 1'b0;
    spikes_s = 4'b0000; lat_s = 0;
    mon_clr = 1'b1;

    // Reset state of both instances.
    @(negedge clk);
    check("reset_small_outputs",
          int'({busy_s, done_s, addr_s, req_s, vm_s, layer_s, tile_s, en_s, mr_s, fin_s, we_s}), 0);
    check("reset_default_outputs",
          int'({busy_d, done_d, addr_d, req_d, vm_d, layer_d, tile_d, en_d, mr_d, fin_d, we_d}), 0);
    rst_s = 1'b0; rst_d = 1'b0;

    // Start -> LDV with request on the next cycle.
    spikes_s = 4'b1111; lat_s = 5;
    @(negedge clk);
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    check("start_to_ldv", int'({busy_s, req_s, vm_s}), 7);
    $display("[TB] start accepted: busy=%0b req=%0b vmem=%0b", busy_s, req_s, vm_s);

    // Reset while a weight request is outstanding.
    seen = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (req_s && !vm_s) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("reach_fetch", int'(seen), 1);
    rst_s = 1'b1;
    @(negedge clk);
    check("reset_mid_fetch_outputs",
          int'({busy_s, done_s, addr_s, req_s, vm_s, layer_s, tile_s, en_s, mr_s, fin_s, we_s}), 0);
    $display("[TB] reset mid-fetch: busy=%0b req=%0b we=%0b", busy_s, req_s, we_s);
    rst_s = 1'b0;

    // Table-driven inferences.
    for (int v = 0; v < 5; v++) begin
      spikes_s = vecs[v].spikes;
      lat_s    = vecs[v].lat;
      run_small(seen, lay, til);
      check($sformatf("v%0d_done_seen", v), int'(seen), 1);
      check($sformatf("v%0d_busy_cycles", v), n_busy, vecs[v].exp_busy);
      check($sformatf("v%0d_memready", v), n_mr, vecs[v].exp_mr);
      check($sformatf("v%0d_weight_req", v), n_wreq, vecs[v].exp_wreq);
      check($sformatf("v%0d_vmem_req", v), n_vreq, vecs[v].exp_vreq);
      check($sformatf("v%0d_finished", v), n_fin, 4);
      check($sformatf("v%0d_vmem_we", v), n_we, 4);
      check($sformatf("v%0d_done_pulses", v), n_done, 1);
      check($sformatf("v%0d_we_order", v), bad_order, 0);
      check($sformatf("v%0d_scan_addrs", v), n_addr, 16);
      check($sformatf("v%0d_addr_seq", v), bad_addr, 0);
      check($sformatf("v%0d_memready_after_ack", v), bad_mr, 0);
      check($sformatf("v%0d_req_hold", v), bad_hold, 0);
      check($sformatf("v%0d_req_len", v), bad_run, 0);
      check($sformatf("v%0d_final_idx", v), lay * 2 + til, 3);
      check($sformatf("v%0d_idle_after", v), int'(busy_s), 0);
      $display("[TB] vec %0d spikes=%b lat=%0d busy=%0d mr=%0d wreq=%0d vreq=%0d we=%0d done=%0d",
               v, vecs[v].spikes, vecs[v].lat, n_busy, n_mr, n_wreq, n_vreq, n_we, n_done);
    end

    // Start held across DONE: one IDLE cycle, then a fresh run.
    spikes_s = 4'b0000; lat_s = 0;
    @(negedge clk);
    start_s = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (done_s) begin
        seen = 1'b1;
        break;
      end
    end
    check("held_start_done", int'(seen), 1);
    @(negedge clk);
    check("held_start_idle_gap", int'(busy_s), 0);
    @(negedge clk);
    check("held_start_restart", int'({busy_s, req_s, vm_s, layer_s, tile_s}), 5'b11100);
    $display("[TB] held start: restart busy=%0b req=%0b vmem=%0b", busy_s, req_s, vm_s);
    start_s = 1'b0;
    rst_s = 1'b1;
    @(negedge clk);
    rst_s = 1'b0;

    // Default sizes, every spike active, zero-latency memory.
    start_d = 1'b1;
    @(negedge clk);
    start_d = 1'b0;
    seen = 1'b0;
    lay = -1; til = -1;
    for (int c = 0; c < 5000; c++) begin
      @(negedge clk);
      if (done_d) begin
        seen = 1'b1;
        lay  = int'(layer_d);
        til  = int'(tile_d);
        break;
      end
    end
    check("default_done_seen", int'(seen), 1);
    check("default_final_layer", lay, 2);
    check("default_final_tile", til, 15);
    @(negedge clk);
    #1;
    check("default_vmem_we", n_we_d, 48);
    check("default_finished", n_fin_d, 48);
    check("default_we_order", bad_order_d, 0);
    check("default_done_pulses", n_done_d, 1);
    check("default_idle_after", int'(busy_d), 0);
    $display("[TB] default run: we=%0d fin=%0d done=%0d layer=%0d tile=%0d",
             n_we_d, n_fin_d, n_done_d, lay, til);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
